data_ram_slave: RTL
===================

// Module: data_ram_slave
// PURPOSE
//  Word-organised data memory that answers load/store requests from the pipelined CPU's MEM stage.
//  Each request completes with a fixed number of wait states and a one-cycle ack.
//  A combinational stall request freezes the pipeline while an access is outstanding.
//  Sits beside the CPU core in the top level; the core is the initiator, this block is the responder.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  WAIT_CYCLES  2   wait states between acceptance and ack (0..15)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   reset, synchronous, active-low (rst==0 on a rising edge resets)
//  ce_i         in   1   request valid; held high by the CPU until ack_o
//  we_i         in   1   1 = store, 0 = load
//  addr_i       in   32  byte address
//  data_i       in   32  store data
//  sel_i        in   4   byte enables; sel_i[3] -> bits 31:24 ... sel_i[0] -> bits 7:0
//  data_o       out  32  load data, valid only while ack_o=1 for a load
//  ack_o        out  1   one-cycle completion pulse
//  stall_req_o  out  1   = ce_i & ~ack_o (combinational), drives the pipeline stall controller
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, wait counter=0, ack_o=0, data_o=0, latched request cleared.
//   - Memory contents are not reset.
//  Address: word index = addr_i[ADDR_WIDTH+1:2]; addr_i[1:0] and higher bits are ignored (aliasing).
//  FSM: IDLE -> WAIT -> ACK -> IDLE.
//   - IDLE: on an edge with ce_i=1, latch we/addr/data/sel and clear the counter.
//     - Next state is WAIT if WAIT_CYCLES>0, else ACK.
//   - WAIT: counter increments each edge.
//     - When counter==WAIT_CYCLES-1: perform the access and go to ACK.
//   - Access: a store writes enabled bytes only; a load registers the full word into data_o.
//   - ACK: ack_o=1 for exactly this cycle; next state is always IDLE.
//     - ce_i is ignored in ACK.
//     - A new request is accepted at the earliest in the following IDLE cycle.
//  Latency: request accepted at edge N -> ack_o high during cycle N+WAIT_CYCLES+1.
//   - With WAIT_CYCLES=0 the ack is in the cycle right after acceptance.
//  With WAIT_CYCLES=0 the access happens on the IDLE->ACK edge.
//  data_o holds its last value outside ACK; only ACK cycles of loads are meaningful.
//  Store timing: the write commits on the edge entering ACK.
//   - A load to the same word issued afterwards returns the new data.
//  Store with sel_i=4'b0000: no memory change, ack still pulses.
//  ce_i or inputs changing after acceptance: ignored; the latched request completes and ack pulses.
//  Reset mid-operation: transaction aborted, no ack.
//   - A store is dropped if reset arrives before its commit edge.
//  stall_req_o is high from the cycle ce_i rises until the ack cycle, low during ack.
// TESTING
//  1. Reset, then store 32'hDEADBEEF to addr 0x10 (sel 4'hF).
//     -> ack exactly 3 cycles after acceptance (WAIT_CYCLES=2).
//     -> a subsequent load of 0x10 returns 32'hDEADBEEF with ack.
//  2. Store 32'h11223344 to 0x20 (sel 4'hF), then store 32'hAABBCCDD with sel 4'b0101.
//     -> load of 0x20 returns 32'h11BB33DD.
//  3. Load from addr 0x23 and from addr (0x20 + 4*2**ADDR_WIDTH).
//     -> both return the word at 0x20 (low bits ignored, aliasing).
//  4. Hold ce_i high continuously for 3 back-to-back loads.
//     -> one ack per WAIT_CYCLES+2 cycles; stall_req_o low only in ack cycles.
//  5. Start a store, assert rst=0 in the first WAIT cycle.
//     -> no ack, ack_o=0, data_o=0.
//     -> a later load of that address returns the old contents.
//  6. Rebuild with WAIT_CYCLES=0 and run a store then a load.
//     -> ack the cycle after acceptance; the load returns the stored data.

Source files
------------

// File: rtl/data_ram_slave.sv
// data_ram_slave: word-organised data memory answering CPU MEM-stage loads/stores.
// Each accepted request waits WAIT_CYCLES states, performs the access, then
// pulses ack_o for one cycle. stall_req_o holds the pipeline while a request
// is outstanding.
module data_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_req_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Counter value on which the access fires; unused when there are no wait states.
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_data;
  logic [3:0]              r_sel;
  logic                    r_ack;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [0:DEPTH-1];

  state_t                  w_state_nxt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_latch;
  logic                    w_access;
  logic                    w_ack_nxt;
  logic                    w_op_we;
  logic [ADDR_WIDTH-1:0]   w_op_idx;
  logic [31:0]             w_op_data;
  logic [3:0]              w_op_sel;
  logic                    w_mem_we;
  logic                    w_load;
  logic                    w_unused;

  // Byte-offset and high address bits are intentionally ignored (aliasing).
  assign w_unused = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // With no wait states the access happens on the accepting edge, so the
  // operands come straight from the inputs; otherwise from the latched request.
  assign w_op_we   = (r_state == ST_IDLE) ? we_i                       : r_we;
  assign w_op_idx  = (r_state == ST_IDLE) ? addr_i[ADDR_WIDTH+1:2]     : r_idx;
  assign w_op_data = (r_state == ST_IDLE) ? data_i                     : r_data;
  assign w_op_sel  = (r_state == ST_IDLE) ? sel_i                      : r_sel;

  // A reset on the commit edge drops the store.
  assign w_mem_we = w_access & w_op_we & rst;
  assign w_load   = w_access & ~w_op_we;

  assign ack_o       = r_ack;
  assign data_o      = r_rdata;
  assign stall_req_o = ce_i & ~r_ack;

  // Next-state logic: sequence IDLE -> WAIT -> ACK -> IDLE and flag the access edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ce_i) begin
          w_latch   = 1'b1;
          w_cnt_nxt = 4'd0;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_ACK;
            w_access    = 1'b1;
            w_ack_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_ACK;
          w_access    = 1'b1;
          w_ack_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control registers, request latch and load data, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_data  <= 32'd0;
      r_sel   <= 4'd0;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      if (w_latch) begin
        r_we   <= we_i;
        r_idx  <= addr_i[ADDR_WIDTH+1:2];
        r_data <= data_i;
        r_sel  <= sel_i;
      end
      if (w_load) begin
        r_rdata <= r_mem[w_op_idx];
      end
    end
  end

  // Memory array: byte-enabled writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_op_sel[b]) begin
          r_mem[w_op_idx][8*b +: 8] <= w_op_data[8*b +: 8];
        end
      end
    end
  end

endmodule
